data_bus_responder: RTL and testbench

//   Target end of the core's data bus: accepts wd/rd requests issued through DataBusControl,

---
 rtl/data_bus_responder_pkg.sv | 54 +++++
 rtl/data_bus_responder_if.sv | 39 +++
 rtl/data_bus_responder_lane_align.sv | 69 ++++++
 rtl/data_bus_responder.sv | 195 +++++++++++++++++++
 tb/tb_data_bus_responder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_responder_pkg
//   Shared definitions for the data-bus responder: bus size codes, FSM state
//   encodings, fault cause codes and the request legality classifier.
//   No ports (package).
// -----------------------------------------------------------------------------
package data_bus_responder_pkg;

    // Width of the wait-state down-counter (WAIT_CYCLES is limited to 0..15).
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        BUS_BYTE = 2'b00,
        BUS_HALF = 2'b01,
        BUS_WORD = 2'b10,
        BUS_RSVD = 2'b11
    } bus_size_e;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_IDLE   = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    typedef enum logic [2:0] {
        FAULT_NONE       = 3'd0,
        FAULT_BOTH_OPS   = 3'd1,
        FAULT_SIZE       = 3'd2,
        FAULT_MISALIGNED = 3'd3,
        FAULT_RANGE      = 3'd4
    } fault_cause_e;

    // Classifies a request presented in IDLE. Only meaningful while wd|rd is
    // high; the caller gates the result with the request strobe.
    function automatic fault_cause_e request_cause(
        input logic       wd,
        input logic       rd,
        input logic [1:0] size,
        input logic       misaligned,
        input logic       in_range
    );
        if (wd && rd)
            return FAULT_BOTH_OPS;
        if (size == BUS_RSVD)
            return FAULT_SIZE;
        if (misaligned)
            return FAULT_MISALIGNED;
        if (!in_range)
            return FAULT_RANGE;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/data_bus_responder_if.sv
// -----------------------------------------------------------------------------
// data_bus_responder_if
//   Core-to-responder data bus.
//   master (core)     : drives wd, rd, size, addr, data_in;
//                       observes ready, busy, data_out, fault.
//   slave (responder) : the mirror image.
//   Signals:
//     ready     responder initialised, may accept requests
//     busy      access in progress, request signals must be held stable
//     wd / rd   write / read request
//     size      00 byte, 01 half, 10 word, 11 reserved
//     addr      byte address (don't-care when wd=rd=0)
//     data_in   write data, right-aligned
//     data_out  read data, right-aligned, zero-extended
//     fault     one-cycle pulse when an illegal request is rejected
// -----------------------------------------------------------------------------
interface data_bus_responder_if;

    logic        ready;
    logic        busy;
    logic        wd;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        fault;

    modport master (
        input  ready, busy, data_out, fault,
        output wd, rd, size, addr, data_in
    );

    modport slave (
        output ready, busy, data_out, fault,
        input  wd, rd, size, addr, data_in
    );

endinterface

// File: rtl/data_bus_responder_lane_align.sv
// -----------------------------------------------------------------------------
// data_bus_responder_lane_align
//   Purely combinational byte-lane steering for a 32-bit word RAM.
//   Inputs:
//     size          access size code (bus_size_e)
//     offset        addr[1:0] of the access
//     data_in       right-aligned write data
//     ram_word      current contents of the addressed RAM word
//   Outputs:
//     byte_en       lanes touched by a write
//     merged_word   ram_word with the enabled lanes replaced by write data
//     aligned_read  selected lane(s) shifted down to bit 0, zero-extended
//     misaligned    half with offset[0]=1, or word with offset!=0
// -----------------------------------------------------------------------------
module data_bus_responder_lane_align
    import data_bus_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data_in,
    input  logic [31:0] ram_word,
    output logic [3:0]  byte_en,
    output logic [31:0] merged_word,
    output logic [31:0] aligned_read,
    output logic        misaligned
);

    // Write data replicated across every lane it could land in, so the
    // byte enables alone decide which lanes are taken.
    logic [31:0] lane_data;

    always_comb begin
        // NOTE: every output is defaulted first so no case branch leaves one
        // unassigned, which would otherwise infer a latch.
        byte_en      = 4'b0000;
        lane_data    = data_in;
        aligned_read = '0;
        misaligned   = 1'b0;
        merged_word  = ram_word;

        case (size)
            BUS_BYTE: begin
                byte_en      = 4'b0001 << offset;
                lane_data    = {4{data_in[7:0]}};
                aligned_read = {24'h0, ram_word[{offset, 3'b000} +: 8]};
            end
            BUS_HALF: begin
                byte_en      = offset[1] ? 4'b1100 : 4'b0011;
                lane_data    = {2{data_in[15:0]}};
                aligned_read = {16'h0, offset[1] ? ram_word[31:16] : ram_word[15:0]};
                misaligned   = offset[0];
            end
            BUS_WORD: begin
                byte_en      = 4'b1111;
                aligned_read = ram_word;
                misaligned   = (offset != 2'b00);
            end
            default: begin
                // Reserved size: no lanes; the top rejects it before access.
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
                merged_word[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
//   Target end of the core's data bus. Serves byte/half/word reads and writes
//   to an internal word-organised RAM, inserts WAIT_CYCLES wait states per
//   access, returns right-aligned zero-extended read data and pulses fault
//   for illegal requests.
//   Parameters:
//     DATA_ADDR_WIDTH  word-address bits (RAM = 2**DATA_ADDR_WIDTH words)
//     BASE_ADDR        byte address of word 0, 4-byte aligned
//     WAIT_CYCLES      extra wait states per access, 0..15
//     CLEAR_ON_RESET   1: zero the RAM one word per cycle after reset
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   data_bus_responder_if.slave (ready, busy, wd, rd, size, addr,
//           data_in, data_out, fault)
// -----------------------------------------------------------------------------
module data_bus_responder
    import data_bus_responder_pkg::*;
#(
    parameter int          DATA_ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          WAIT_CYCLES     = 1,
    parameter bit          CLEAR_ON_RESET  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_bus_responder_if.slave  bus
);

    localparam int                DEPTH     = 2 ** DATA_ADDR_WIDTH;
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    // ---------------------------------------------------------------- state
    state_e                     state;
    logic [DATA_ADDR_WIDTH-1:0] clear_cnt;
    logic [WAIT_W-1:0]          wait_cnt;

    // Request captured in the accept cycle; the bus may change afterwards.
    logic                       write_q;
    logic [1:0]                 size_q;
    logic [1:0]                 offset_q;
    logic [DATA_ADDR_WIDTH-1:0] word_q;
    logic [31:0]                data_q;

    logic                       ready_q;
    logic                       fault_q;
    logic [31:0]                data_out_q;

    logic [31:0]                mem [DEPTH];

    // ---------------------------------------------------------- decode wires
    logic                       request;
    logic [31:0]                rel_addr;
    logic                       in_range;
    fault_cause_e               cause;
    logic                       accept;
    logic                       commit;

    logic [1:0]                 align_size;
    logic [1:0]                 align_offset;
    logic [3:0]                 byte_en;
    logic [31:0]                merged_word;
    logic [31:0]                aligned_read;
    logic                       misaligned;

    logic [DATA_ADDR_WIDTH-1:0] mem_addr;
    logic                       mem_we;
    logic [3:0]                 mem_be;
    logic [31:0]                mem_wdata;
    logic [31:0]                ram_word;

    // ------------------------------------------------------ request checking
    assign request  = bus.wd | bus.rd;
    assign rel_addr = bus.addr - BASE_ADDR;

    // Unsigned 32-bit arithmetic: below BASE_ADDR is caught explicitly, and
    // one byte past the top word lands at index DEPTH, which is out of range.
    assign in_range = (bus.addr >= BASE_ADDR) && ((rel_addr >> 2) < 32'(DEPTH));

    // The aligner checks the live request while idle and steers the latched
    // request during the access; it is never needed for both at once.
    assign align_size   = (state == ST_ACCESS) ? size_q   : bus.size;
    assign align_offset = (state == ST_ACCESS) ? offset_q : bus.addr[1:0];

    assign cause  = request_cause(bus.wd, bus.rd, bus.size, misaligned, in_range);
    assign accept = (state == ST_IDLE) && request && (cause == FAULT_NONE);
    assign commit = (state == ST_ACCESS) && (wait_cnt == '0);

    data_bus_responder_lane_align u_lane_align (
        .size         (align_size),
        .offset       (align_offset),
        .data_in      (data_q),
        .ram_word     (ram_word),
        .byte_en      (byte_en),
        .merged_word  (merged_word),
        .aligned_read (aligned_read),
        .misaligned   (misaligned)
    );

    // ---------------------------------------------------------------- RAM
    // Single port: the INIT sweep owns the address until the first request.
    assign mem_addr  = (state == ST_INIT) ? clear_cnt : word_q;
    assign mem_we    = ((state == ST_INIT) && CLEAR_ON_RESET) || (commit && write_q);
    assign mem_be    = (state == ST_INIT) ? 4'b1111 : byte_en;
    assign mem_wdata = (state == ST_INIT) ? 32'h0 : merged_word;
    assign ram_word  = mem[mem_addr];

    // NOTE: the RAM array has no reset term; zeroing, when wanted, is done
    // one word per cycle by the INIT sweep instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i])
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_INIT;
            clear_cnt  <= '0;
            wait_cnt   <= '0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            offset_q   <= 2'b00;
            word_q     <= '0;
            data_q     <= 32'h0;
            ready_q    <= 1'b0;
            fault_q    <= 1'b0;
            data_out_q <= 32'h0;
        end else begin
            fault_q <= 1'b0;

            case (state)
                ST_INIT: begin
                    // Requests seen here are ignored outright, no fault.
                    if (!CLEAR_ON_RESET || (&clear_cnt)) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (accept) begin
                        write_q  <= bus.wd;
                        size_q   <= bus.size;
                        offset_q <= bus.addr[1:0];
                        word_q   <= rel_addr[DATA_ADDR_WIDTH+1:2];
                        data_q   <= bus.data_in;
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_ACCESS;
                    end else if (request) begin
                        // Illegal: no access, RAM and data_out untouched.
                        fault_q <= 1'b1;
                        state   <= ST_DONE;
                    end
                end

                ST_ACCESS: begin
                    if (commit) begin
                        // Write lanes are merged by the RAM block on this edge.
                        if (!write_q)
                            data_out_q <= aligned_read;
                        state <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    // The core still holds its old request here while it
                    // advances; ignoring wd/rd prevents a repeated access.
                    state <= ST_IDLE;
                end

                default: state <= ST_INIT;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    // busy must rise in the accept cycle itself, so it is decoded, not stored.
    assign bus.busy     = accept || (state == ST_ACCESS);
    assign bus.ready    = ready_q;
    assign bus.fault    = fault_q;
    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_data_bus_responder
//   Three responders (16 words, base 0, clear on reset) with WAIT_CYCLES of
//   1, 0 and 3, driven independently through their own bus interfaces.
// -----------------------------------------------------------------------------
module tb_data_bus_responder;
    import data_bus_responder_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        wd_v    [NDUT];
    logic        rd_v    [NDUT];
    logic [1:0]  size_v  [NDUT];
    logic [31:0] addr_v  [NDUT];
    logic [31:0] din_v   [NDUT];
    logic        ready_v [NDUT];
    logic        busy_v  [NDUT];
    logic        fault_v [NDUT];
    logic [31:0] dout_v  [NDUT];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        data_bus_responder_if bus ();

        assign bus.wd      = wd_v[g];
        assign bus.rd      = rd_v[g];
        assign bus.size    = size_v[g];
        assign bus.addr    = addr_v[g];
        assign bus.data_in = din_v[g];
        assign ready_v[g]  = bus.ready;
        assign busy_v[g]   = bus.busy;
        assign fault_v[g]  = bus.fault;
        assign dout_v[g]   = bus.data_out;

        data_bus_responder #(
            .DATA_ADDR_WIDTH (4),
            .BASE_ADDR       (32'h0000_0000),
            .WAIT_CYCLES     ((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .CLEAR_ON_RESET  (1'b1)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        w;
        logic        r;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_out;
        logic        exp_fault;
        string       name;
    } vec_t;

    vec_t vecs [$];

    function automatic void add_vec(input logic w, input logic r, input logic [1:0] sz,
                                    input logic [31:0] a, input logic [31:0] d,
                                    input logic [31:0] exp_out, input logic exp_fault,
                                    input string name);
        vec_t v;
        v.w = w; v.r = r; v.sz = sz; v.a = a; v.d = d;
        v.exp_out = exp_out; v.exp_fault = exp_fault; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic idle_bus(input int k);
        wd_v[k]   = 1'b0;
        rd_v[k]   = 1'b0;
        size_v[k] = 2'b00;
        addr_v[k] = 'z;
        din_v[k]  = 'z;
    endtask

    // Presents a request at a negedge (cycle T), scrambles addr/size/data
    // while busy, keeps wd/rd asserted through DONE, then drops them just
    // after the edge that ends DONE and samples one further cycle.
    task automatic do_access(input int k, input logic w, input logic r, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] dout, output int busy_cnt,
                             output int fault_cnt, output int done_at,
                             output logic post_busy);
        int n;
        @(negedge clk);
        wd_v[k] = w; rd_v[k] = r; size_v[k] = sz; addr_v[k] = a; din_v[k] = d;
        #1;
        busy_cnt  = busy_v[k]  ? 1 : 0;
        fault_cnt = fault_v[k] ? 1 : 0;
        done_at   = -1;
        n         = 0;
        dout      = 32'hxxxx_xxxx;
        while (done_at < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (fault_v[k]) fault_cnt++;
            if (busy_v[k]) begin
                busy_cnt++;
                addr_v[k] = a ^ 32'h0000_0024;
                size_v[k] = sz ^ 2'b01;
                din_v[k]  = ~d;
            end else begin
                done_at = n;
                dout    = dout_v[k];
            end
        end
        @(posedge clk);
        #1;
        idle_bus(k);
        @(negedge clk);
        post_busy = busy_v[k];
        if (fault_v[k]) fault_cnt++;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        logic [31:0] dout;
        int          busy_cnt, fault_cnt, done_at, w;
        logic        post_busy;
        w = wait_of(k);
        do_access(k, v.w, v.r, v.sz, v.a, v.d, dout, busy_cnt, fault_cnt, done_at, post_busy);
        check({v.name, " data_out"},     dout,             v.exp_out);
        check({v.name, " busy cycles"},  32'(busy_cnt),    v.exp_fault ? 32'd0 : 32'(w + 2));
        check({v.name, " done offset"},  32'(done_at),     v.exp_fault ? 32'd1 : 32'(w + 2));
        check({v.name, " fault pulses"}, 32'(fault_cnt),   v.exp_fault ? 32'd1 : 32'd0);
        check({v.name, " no re-access"}, {31'h0, post_busy}, 32'd0);
    endtask

    task automatic wait_all_ready(input string name);
        int n = 0;
        while (!(ready_v[0] && ready_v[1] && ready_v[2]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'h0, (n < 100)}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt, fault_seen, busy_seen;

        for (int k = 0; k < NDUT; k++) idle_bus(k);

        // ---------------------------------------------------- reset and INIT
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset ready",    {31'h0, ready_v[0]}, 32'd0);
        check("reset busy",     {31'h0, busy_v[0]},  32'd0);
        check("reset fault",    {31'h0, fault_v[0]}, 32'd0);
        check("reset data_out", dout_v[0],           32'h0);

        // A write presented during INIT must be ignored without a fault.
        wd_v[0] = 1'b1; size_v[0] = BUS_WORD; addr_v[0] = 32'h0; din_v[0] = 32'hFFFF_FFFF;
        rst = 1'b0;
        cnt = 0; fault_seen = 0; busy_seen = 0;
        while (!ready_v[0] && cnt < 100) begin
            cnt++;
            if (fault_v[0]) fault_seen++;
            if (busy_v[0])  busy_seen++;
            if (cnt == 10) idle_bus(0);
            @(negedge clk);
        end
        check("init ready-low cycles", 32'(cnt),        32'd16);
        check("init request no fault", 32'(fault_seen), 32'd0);
        check("init request no busy",  32'(busy_seen),  32'd0);
        check("init dut1 ready",       {31'h0, ready_v[1]}, 32'd1);
        check("init dut2 ready",       {31'h0, ready_v[2]}, 32'd1);

        // ------------------------------------------- table vectors, WAIT=1
        //       wd    rd    size      addr           data_in        data_out       fault
        add_vec(1'b1, 1'b0, BUS_WORD, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, "sw_08");
        add_vec(1'b0, 1'b1, BUS_BYTE, 32'h0000_0009, 32'h0,         32'h0000_00BE, 1'b0, "lb_09");
        add_vec(1'b0, 1'b1, BUS_HALF, 32'h0000_000A, 32'h0,         32'h0000_DEAD, 1'b0, "lh_0a");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, "lw_08");
        add_vec(1'b1, 1'b0, BUS_BYTE, 32'h0000_000B, 32'hFFFF_FF55, 32'hDEAD_BEEF, 1'b0, "sb_0b");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0008, 32'h0,         32'h55AD_BEEF, 1'b0, "lw_08_merged");
        add_vec(1'b0, 1'b1, BUS_HALF, 32'h0000_0003, 32'h0,         32'h55AD_BEEF, 1'b1, "lh_03_misaligned");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0006, 32'h0,         32'h55AD_BEEF, 1'b1, "lw_06_misaligned");
        add_vec(1'b0, 1'b1, BUS_RSVD, 32'h0000_0008, 32'h0,         32'h55AD_BEEF, 1'b1, "size_reserved");
        add_vec(1'b1, 1'b1, BUS_WORD, 32'h0000_0008, 32'h1111_1111, 32'h55AD_BEEF, 1'b1, "wd_rd_both");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0040, 32'h0,         32'h55AD_BEEF, 1'b1, "lw_40_range");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0008, 32'h0,         32'h55AD_BEEF, 1'b0, "lw_08_after_faults");
        add_vec(1'b1, 1'b0, BUS_HALF, 32'h0000_0006, 32'hAAAA_CAFE, 32'h55AD_BEEF, 1'b0, "sh_06");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0004, 32'h0,         32'hCAFE_0000, 1'b0, "lw_04");
        add_vec(1'b0, 1'b1, BUS_BYTE, 32'h0000_0007, 32'h0,         32'h0000_00CA, 1'b0, "lb_07");
        add_vec(1'b0, 1'b1, BUS_BYTE, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, "lb_00_cleared");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_003C, 32'h0,         32'h0000_0000, 1'b0, "lw_3c_top");
        add_vec(1'b1, 1'b0, BUS_WORD, 32'h0000_003C, 32'h0102_0304, 32'h0000_0000, 1'b0, "sw_3c");
        add_vec(1'b0, 1'b1, BUS_BYTE, 32'h0000_003C, 32'h0,         32'h0000_0004, 1'b0, "lb_3c");
        add_vec(1'b0, 1'b1, BUS_HALF, 32'h0000_003E, 32'h0,         32'h0000_0102, 1'b0, "lh_3e");
        add_vec(1'b1, 1'b0, BUS_BYTE, 32'h0000_0041, 32'h0000_00EE, 32'h0000_0102, 1'b1, "sb_41_range");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_003C, 32'h0,         32'h0102_0304, 1'b0, "lw_3c");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'hFFFF_FFFC, 32'h0,         32'h0102_0304, 1'b1, "lw_high_range");

        foreach (vecs[i]) run_vec(0, vecs[i]);

        // ------------------------------------ reset in the middle of a write
        @(negedge clk);
        wd_v[0] = 1'b1; size_v[0] = BUS_WORD; addr_v[0] = 32'h0; din_v[0] = 32'h1234_5678;
        @(posedge clk);
        #1;
        check("midreset busy before", {31'h0, busy_v[0]}, 32'd1);
        rst = 1'b1;
        #1;
        check("midreset ready",    {31'h0, ready_v[0]}, 32'd0);
        check("midreset busy",     {31'h0, busy_v[0]},  32'd0);
        check("midreset fault",    {31'h0, fault_v[0]}, 32'd0);
        check("midreset data_out", dout_v[0],           32'h0);
        idle_bus(0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_all_ready("midreset reinit");

        vecs.delete();
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0000, 32'h0, 32'h0000_0000, 1'b0, "lw_00_dropped");
        foreach (vecs[i]) run_vec(0, vecs[i]);

        // --------------------------------- held request, WAIT=0 and WAIT=3
        vecs.delete();
        add_vec(1'b1, 1'b0, BUS_WORD, 32'h0000_0010, 32'hA5C3_5A3C, 32'h0000_0000, 1'b0, "held_sw_10");
        add_vec(1'b0, 1'b1, BUS_WORD, 32'h0000_0010, 32'h0,         32'hA5C3_5A3C, 1'b0, "held_lw_10");
        add_vec(1'b0, 1'b1, BUS_BYTE, 32'h0000_0012, 32'h0,         32'h0000_00C3, 1'b0, "held_lb_12");
        add_vec(1'b0, 1'b1, BUS_HALF, 32'h0000_0011, 32'h0,         32'h0000_00C3, 1'b1, "held_lh_11");
        for (int k = 1; k < NDUT; k++) begin
            foreach (vecs[i]) run_vec(k, vecs[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
